// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO write-side control blocks.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int FIFO_DW = 8;

  // Index width for a vector of n entries; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or above rr_ptr, wrapping modulo N_REQ.
// Purely combinational, no backpressure.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    pick,
  output logic             any_req
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    pick    = '0;
    idx     = '0;
    any_req = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ packet requesters.
// One IDLE cycle to grant, then one beat per clock; fifo_full stalls the beat combinationally.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DW-1:0]            fifo_din,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(N_REQ - 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          accept;
  logic          release_grant;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // rst gates the write so an abandoned packet never leaks a beat into the FIFO.
  assign accept        = (state == LOCK) && req[grant_id] && !fifo_full && !rst;
  assign release_grant = req_last[grant_id] || (burst_cnt == BURST_LAST);

  always_comb begin
    req_ack           = '0;
    req_ack[grant_id] = accept;
    fifo_wr_en        = accept;
    fifo_din          = req_data[grant_id*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (accept) begin
            if (release_grant) begin
              state     <= IDLE;
              busy      <= 1'b0;
              burst_cnt <= '0;
              // Just-served requester drops to lowest priority.
              rr_ptr    <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter with a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ack;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DW        (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] din;
    logic [N-1:0]  ack;
    logic          busy;
    logic [1:0]    gid;
  } exp_t;

  exp_t expq[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Pending beats per requester; head is the beat currently offered.
  logic [DW-1:0] bq[N][$];
  bit            lq[N][$];
  logic [N-1:0]  seen_ack = '0;
  int            req_prob = 100;

  // Reference model: who owns the port, how many beats it has sent, who is next in line.
  int m_owner = -1;
  int m_gid   = 0;
  int m_next  = 0;
  int m_beats = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += bq[i].size();
    return s;
  endfunction

  task automatic push_pkt(int r, int len, logic [DW-1:0] base, logic [DW-1:0] step);
    for (int k = 0; k < len; k++) begin
      bq[r].push_back(base + DW'(k) * step);
      lq[r].push_back(k == len - 1);
    end
  endtask

  task automatic model_step(bit rst_v);
    exp_t e;
    e.busy = (m_owner >= 0);
    e.gid  = 2'(m_gid);
    e.din  = req_data[m_gid*DW +: DW];
    e.wr   = 1'b0;
    e.ack  = '0;
    if (rst_v) begin
      m_owner = -1;
      m_gid   = 0;
      m_next  = 0;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_next + k) % N]) m_owner = (m_next + k) % N;
      end
      if (m_owner >= 0) begin
        m_gid   = m_owner;
        m_beats = 0;
      end
    end else if (req[m_owner] && !fifo_full) begin
      e.wr          = 1'b1;
      e.ack[m_owner] = 1'b1;
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    expq.push_back(e);
  endtask

  task automatic tick(bit rst_v, bit full_v, logic [N-1:0] gate);
    logic [DW-1:0] tmp_d;
    bit            tmp_l;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (seen_ack[i] && bq[i].size() > 0) begin
        tmp_d = bq[i].pop_front();
        tmp_l = lq[i].pop_front();
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0) begin
        req[i]                = gate[i] && ($urandom_range(99) < req_prob);
        req_data[i*DW +: DW]  = bq[i][0];
        req_last[i]           = lq[i][0];
      end else begin
        req[i]                = 1'b0;
        req_data[i*DW +: DW]  = DW'($urandom);
        req_last[i]           = 1'($urandom);
      end
    end
    rst       = rst_v;
    fifo_full = full_v;
    model_step(rst_v);
  endtask

  task automatic drain(int full_pct, int rst_pct);
    int n = 0;
    while (pending() > 0 && n < 4000) begin
      tick($urandom_range(99) < rst_pct, $urandom_range(99) < full_pct, '1);
      n++;
    end
    chk("drained", pending(), 0);
    tick(1'b0, 1'b0, '1);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      seen_ack = req_ack;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("fifo_wr_en", fifo_wr_en, e.wr);
        chk("req_ack", req_ack, e.ack);
        chk("busy", busy, e.busy);
        chk("grant_id", grant_id, e.gid);
        if (e.busy) chk("fifo_din", fifo_din, e.din);
      end
    end
  end

  initial begin
    tick(1'b1, 1'b0, '1);
    tick(1'b1, 1'b0, '1);

    // Single 3-beat packet from requester 0.
    push_pkt(0, 3, 8'h11, 8'h11);
    drain(0, 0);

    // Round robin with 1-beat packets from everyone.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, DW'(8'h40 + 8'(i * 16 + r)), 8'h00);
    drain(0, 0);

    // Full stall in the middle of requester 2's packet.
    push_pkt(2, 4, 8'hA0, 8'h01);
    tick(1'b0, 1'b0, '1);
    tick(1'b0, 1'b0, '1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, '1);
    drain(0, 0);

    // Burst limit: long packet competing with a short one.
    push_pkt(1, 10, 8'h01, 8'h01);
    push_pkt(3, 2, 8'hC0, 8'h01);
    drain(0, 0);

    // Reset during beat 2 of a 4-beat packet, then 0 must win over 3.
    push_pkt(3, 4, 8'hD0, 8'h01);
    tick(1'b0, 1'b0, '1);
    tick(1'b0, 1'b0, '1);
    push_pkt(0, 1, 8'h5A, 8'h00);
    tick(1'b1, 1'b0, '1);
    drain(0, 0);

    // Granted requester goes quiet for 3 cycles while another waits.
    push_pkt(0, 4, 8'hE0, 8'h01);
    push_pkt(1, 2, 8'hF0, 8'h01);
    tick(1'b0, 1'b0, '1);
    tick(1'b0, 1'b0, '1);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b1110);
    drain(0, 0);

    // Randomized traffic with gaps, full stalls and occasional resets.
    req_prob = 70;
    for (int p = 0; p < 60; p++)
      push_pkt($urandom_range(N - 1), $urandom_range(8, 1), DW'($urandom), DW'($urandom_range(255, 1)));
    drain(25, 2);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's 8-bit FIFO among N_REQ packet-oriented requesters.
- Grants one requester at a time and holds the grant until that requester's last beat or a burst limit.
- Throttles every beat on the FIFO full flag.
- Sits entirely in the FIFO write-clock domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width; matches FIFO buf_in
MAX_BURST, 16, max beats per grant before forced re-arbitration (>=1)

Ports:
clk  in  1  write-domain clock
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester beat valid
req_data  in  N_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
req_last  in  N_REQ  per-requester end-of-packet marker, qualified by req
req_ack  out  N_REQ  one-hot; beat of requester i accepted this cycle
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_din  out  DW  FIFO write data
grant_id  out  $clog2(N_REQ)  currently granted requester; valid when busy=1
busy  out  1  a grant is held (LOCK state)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All state updates on the posedge of clk; rst is sampled there.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, burst_cnt=0.
- While rst=1, fifo_wr_en=0 and req_ack=0 (forced combinationally).
- State machine: two states, IDLE and LOCK.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Register the pick into grant_id, set burst_cnt=0, go to LOCK.
  - No beat is accepted in IDLE. Arbitration latency is 1 cycle from req to first possible ack.
- LOCK:
  - accept = req[grant_id] & ~fifo_full.
  - fifo_wr_en = accept; fifo_din = req_data[grant_id]; req_ack[grant_id] = accept.
  - These outputs are combinational, so the FIFO sees zero-cycle throttle.
  - fifo_din mirrors the granted requester's data even when fifo_wr_en=0.
  - On accept: burst_cnt increments.
  - If req_last[grant_id]=1 or burst_cnt==MAX_BURST-1: go to IDLE and set rr_ptr=(grant_id+1) mod N_REQ.
  - Otherwise stay in LOCK.
- Throughput: one beat per clock while the FIFO is not full.
- Requester gaps: if the granted requester drops req mid-packet, the grant is held (no timeout). Other requesters wait.
- Full: fifo_full=1 stalls the beat; state, burst_cnt and grant are unchanged. No data is lost or duplicated.
- Priority fairness: after a grant ends, the just-served requester has lowest priority.
  - Worst-case wait is (N_REQ-1) grants of at most MAX_BURST beats each, plus full stalls.
- Back-to-back grants: each grant ends with one IDLE cycle, so there is one bubble between packets.
- Wrap-around:
  - rr_ptr wraps from N_REQ-1 to 0.
  - burst_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
- Simultaneous last and burst limit on the same beat: a single release, same as either alone.
- Reset mid-packet: the packet is abandoned and no write occurs in the reset cycle. Post-reset arbitration restarts at requester 0.
- req_last without req is ignored.

Decomposition:
- Shared package fifo_ctrl_pkg:
  - state enum (IDLE, LOCK);
  - localparam helpers for the grant index width;
  - FIFO data width constant (8).
- One natural sub-module: rr_pick. It is purely combinational:
  - inputs req vector and rr_ptr;
  - outputs grant index and any_req.
- Its search wraps modulo N_REQ.

Test Plan:
- Single packet: req0 sends 3 beats (0x11, 0x22, 0x33), last on 0x33, fifo_full=0.
  - Cycle 0: busy=0.
  - Cycles 1-3: fifo_wr_en=1 carrying 0x11/0x22/0x33, req_ack=0001.
  - Cycle 4: busy=0, rr_ptr=1.
- Round robin: req0 through req3 all request continuously with 1-beat packets.
  - Grant order is 0,1,2,3,0.
  - Each grant is followed by one bubble cycle.
- Full stall: requester 2 is mid-packet, fifo_full=1 for 5 cycles.
  - fifo_wr_en=0 and req_ack=0 for those 5 cycles; grant_id stays 2.
  - After full releases, the next beat is written exactly once.
- Burst limit: MAX_BURST=4, req1 streams 10 beats with no last, req3 also requesting.
  - req1 gets beats 1-4, then req3 is granted.
  - req1 resumes with beat 5 later.
- Reset mid-packet: rst=1 for 1 cycle during beat 2 of a 4-beat packet from req3.
  - No write occurs in the reset cycle; busy=0 and grant_id=0 the next cycle.
  - With req0 and req3 requesting, req0 is granted first.
- Gap hold: granted requester drops req for 3 cycles while another requester requests.
  - busy stays 1 and grant_id is unchanged.
  - No writes occur for those 3 cycles.
